// File: rtl/audio_sample_sink_if.sv
// Purpose: look-ahead MMIO bus between the picorv32 core and the audio sink.
// Signals: mem_la_read/mem_la_write strobes, mem_la_addr, mem_la_wdata from
//          the CPU; rdata (registered STATUS read data) back to the CPU.
interface audio_sample_sink_if;
  logic        mem_la_read;
  logic        mem_la_write;
  logic [31:0] mem_la_addr;
  logic [31:0] mem_la_wdata;
  logic [31:0] rdata;

  modport master (
    output mem_la_read, mem_la_write, mem_la_addr, mem_la_wdata,
    input  rdata
  );

  modport slave (
    input  mem_la_read, mem_la_write, mem_la_addr, mem_la_wdata,
    output rdata
  );
endinterface

// File: rtl/audio_sample_sink.sv
// Purpose: captures firmware LEFT/RIGHT sample stores, pairs them into
//          stereo frames, buffers them in a FIFO and releases one frame per
//          sample_tick; counts underflows and flags overflow in STATUS.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   bus (slave)       CPU look-ahead MMIO bus; rdata returns STATUS
//   sample_tick       one-cycle strobe at the output sample rate
//   sample_l/r        current stereo frame (signed), muted on underflow
//   sample_valid      one-cycle pulse: new frame on sample_l/r
//   underflow         one-cycle pulse: tick arrived with the FIFO empty
module audio_sample_sink #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned SAMPLE_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  audio_sample_sink_if.slave         bus,
  input  logic                       sample_tick,
  output logic signed [SAMPLE_W-1:0] sample_l,
  output logic signed [SAMPLE_W-1:0] sample_r,
  output logic                       sample_valid,
  output logic                       underflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = AW + 1;

  localparam logic [31:0] ADDR_LEFT   = BASE_ADDR + 32'h10;
  localparam logic [31:0] ADDR_RIGHT  = BASE_ADDR + 32'h20;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h24;
  localparam logic [31:0] ADDR_CTRL   = BASE_ADDR + 32'h28;

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } frame_t;

  frame_t              mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LW-1:0]       level;
  logic                overflow;
  logic [15:0]         underflow_cnt;
  logic [SAMPLE_W-1:0] left_hold;

  logic wr_left, wr_right, flush, rd_status;
  logic empty, full, pop, push_ok;
  logic unused_wdata;

  // Register decode: full 32-bit address match, qualified by the strobes.
  assign wr_left   = bus.mem_la_write && (bus.mem_la_addr == ADDR_LEFT);
  assign wr_right  = bus.mem_la_write && (bus.mem_la_addr == ADDR_RIGHT);
  assign flush     = bus.mem_la_write && (bus.mem_la_addr == ADDR_CTRL) && bus.mem_la_wdata[0];
  assign rd_status = bus.mem_la_read  && (bus.mem_la_addr == ADDR_STATUS);

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  // Emptiness is judged before any same-cycle push, so a push never bypasses.
  assign pop = sample_tick && !empty && !flush;
  // A push into a full FIFO only lands when a pop frees the slot this cycle.
  assign push_ok = wr_right && (!full || pop) && !flush;

  assign unused_wdata = ^bus.mem_la_wdata;

  // Frame storage; left unreset so it maps onto a plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {left_hold, bus.mem_la_wdata[SAMPLE_W-1:0]};
    end
  end

  // FIFO control, counters and sample output.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      overflow      <= 1'b0;
      underflow_cnt <= '0;
      left_hold     <= '0;
      sample_l      <= '0;
      sample_r      <= '0;
      sample_valid  <= 1'b0;
      underflow     <= 1'b0;
    end else if (flush) begin
      // Flush wins over push/pop/tick; sample_l/r hold their last value.
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      overflow      <= 1'b0;
      underflow_cnt <= '0;
      left_hold     <= '0;
      sample_valid  <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      if (wr_left) begin
        left_hold <= bus.mem_la_wdata[SAMPLE_W-1:0];
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr_right && !push_ok) begin
        overflow <= 1'b1;
      end

      if (push_ok && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push_ok) begin
        level <= level - LW'(1);
      end

      sample_valid <= sample_tick;
      underflow    <= sample_tick && empty;

      if (pop) begin
        sample_l <= mem[rd_ptr].l;
        sample_r <= mem[rd_ptr].r;
      end else if (sample_tick) begin
        sample_l <= '0;
        sample_r <= '0;
      end

      if (sample_tick && empty && (underflow_cnt != 16'hFFFF)) begin
        underflow_cnt <= underflow_cnt + 16'd1;
      end
    end
  end

  // STATUS read path; rdata holds between read strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rdata <= '0;
    end else if (bus.mem_la_read) begin
      bus.rdata <= rd_status ? {underflow_cnt, overflow, 15'(level)} : 32'h0;
    end
  end

endmodule

// File: tb/tb_audio_sample_sink.sv
// Purpose: self-checking bench for audio_sample_sink; directed scenarios
//          followed by randomized MMIO/tick traffic, all checked against a
//          queue-based behavioural model of the sink.
module tb_audio_sample_sink;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] A_L   = BASE + 32'h10;
  localparam logic [31:0] A_R   = BASE + 32'h20;
  localparam logic [31:0] A_ST  = BASE + 32'h24;
  localparam logic [31:0] A_CT  = BASE + 32'h28;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        underflow;

  audio_sample_sink_if bus ();

  audio_sample_sink #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH),
    .SAMPLE_W  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .sample_tick  (sample_tick),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Behavioural model state.
  logic [31:0] q[$];
  logic [15:0] m_hold;
  logic        m_ovf;
  logic [15:0] m_ucnt;
  logic [15:0] e_l, e_r;
  logic        e_valid, e_uf;
  logic [31:0] e_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus: model the cycle, clock it, compare every output.
  task automatic step(input logic rst, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wd, input logic tk);
    logic [31:0] status;
    logic [31:0] f;
    reset            = rst;
    bus.mem_la_read  = rd;
    bus.mem_la_write = wr;
    bus.mem_la_addr  = addr;
    bus.mem_la_wdata = wd;
    sample_tick      = tk;

    status = {m_ucnt, m_ovf, 15'(q.size())};
    if (rst) begin
      q.delete();
      m_hold = '0; m_ovf = 1'b0; m_ucnt = '0;
      e_l = '0; e_r = '0; e_valid = 1'b0; e_uf = 1'b0; e_rdata = '0;
    end else begin
      if (rd) e_rdata = (addr == A_ST) ? status : 32'h0;
      if (wr && addr == A_CT && wd[0]) begin
        q.delete();
        m_hold = '0; m_ovf = 1'b0; m_ucnt = '0;
        e_valid = 1'b0; e_uf = 1'b0;
      end else begin
        e_valid = tk;
        e_uf    = 1'b0;
        if (tk) begin
          if (q.size() > 0) begin
            f   = q.pop_front();
            e_l = f[31:16];
            e_r = f[15:0];
          end else begin
            e_l = '0; e_r = '0; e_uf = 1'b1;
            if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
          end
        end
        if (wr && addr == A_L) m_hold = wd[15:0];
        if (wr && addr == A_R) begin
          if (q.size() < DEPTH) q.push_back({m_hold, wd[15:0]});
          else                  m_ovf = 1'b1;
        end
      end
    end

    @(posedge clk);
    #1;
    check("sample_valid", 32'(sample_valid), 32'(e_valid));
    check("underflow",    32'(underflow),    32'(e_uf));
    check("sample_l",     32'(sample_l),     32'(e_l));
    check("sample_r",     32'(sample_r),     32'(e_r));
    check("rdata",        bus.rdata,         e_rdata);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic tk);
    step(1'b0, 1'b0, 1'b1, a, d, tk);
  endtask

  task automatic rd(input logic [31:0] a, input logic tk);
    step(1'b0, 1'b1, 1'b0, a, 32'h0, tk);
  endtask

  task automatic tick();
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    wr(A_L, {16'h0, l}, 1'b0);
    wr(A_R, {16'h0, r}, 1'b0);
  endtask

  initial begin
    reset = 1'b1; sample_tick = 1'b0;
    bus.mem_la_read = 1'b0; bus.mem_la_write = 1'b0;
    bus.mem_la_addr = '0;   bus.mem_la_wdata = '0;
    m_hold = '0; m_ovf = 1'b0; m_ucnt = '0;
    e_l = '0; e_r = '0; e_valid = 1'b0; e_uf = 1'b0; e_rdata = '0;

    // Reset state.
    do_reset();
    check("rst_status", 32'(dut.level), 32'h0);

    // Single frame round trip.
    push(16'h1234, 16'hABCD);
    tick();
    check("t1_l", 32'(sample_l), 32'h1234);
    check("t1_r", 32'(sample_r), 32'hABCD);
    rd(A_ST, 1'b0);
    check("t1_status", bus.rdata, 32'h0000_0000);

    // Three underflows on an empty FIFO.
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    rd(A_ST, 1'b0);
    check("t2_status", bus.rdata, 32'h0003_0000);

    // Overflow: 65th frame dropped, first 64 drain in order.
    do_reset();
    for (int i = 0; i < 65; i++) push(16'(i), 16'(16'h8000 + i));
    rd(A_ST, 1'b0);
    check("t3_status", bus.rdata, 32'h0000_8040);
    for (int i = 0; i < 64; i++) tick();
    check("t3_last_l", 32'(sample_l), 32'd63);
    tick();
    check("t3_uf", 32'(underflow), 32'h1);

    // Push and pop together while full.
    do_reset();
    for (int i = 0; i < 64; i++) push(16'(i + 100), 16'(i));
    wr(A_R, 32'h0000_5555, 1'b1);
    check("t4_head", 32'(sample_l), 32'd100);
    rd(A_ST, 1'b0);
    check("t4_status", bus.rdata, 32'h0000_0040);

    // LEFT hold reuse across two RIGHT writes.
    do_reset();
    wr(A_L, 32'h0000_7FFF, 1'b0);
    wr(A_R, 32'h0000_0001, 1'b0);
    wr(A_R, 32'h0000_0002, 1'b0);
    tick();
    check("t5_l0", 32'(sample_l), 32'h7FFF);
    tick();
    check("t5_l1", 32'(sample_l), 32'h7FFF);
    check("t5_r1", 32'(sample_r), 32'h0002);

    // Flush overriding a tick, then reset mid-drain.
    do_reset();
    for (int i = 0; i < 10; i++) push(16'(i + 1), 16'(i + 1));
    wr(A_CT, 32'h0000_0001, 1'b1);
    check("t6_novalid", 32'(sample_valid), 32'h0);
    rd(A_ST, 1'b0);
    check("t6_status", bus.rdata, 32'h0);
    for (int i = 0; i < 5; i++) push(16'(i + 7), 16'(i + 9));
    tick();
    tick();
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("t6_rst_l", 32'(sample_l), 32'h0);
    tick();
    check("t6_rst_uf", 32'(underflow), 32'h1);

    // Randomized traffic: slow ticks first to reach overflow, then fast.
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      int unsigned tick_pct;
      tick_pct = (ph == 0) ? 8 : (ph == 1) ? 55 : 30;
      for (int i = 0; i < 1500; i++) begin
        int unsigned sel;
        logic        tk;
        logic [31:0] d;
        sel = $urandom_range(0, 99);
        tk  = ($urandom_range(0, 99) < tick_pct);
        d   = $urandom;
        if ($urandom_range(0, 599) == 0)  step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, tk);
        else if (sel < 25)                wr(A_L, d, tk);
        else if (sel < 60)                wr(A_R, d, tk);
        else if (sel < 70)                rd(A_ST, tk);
        else if (sel < 73)                rd(A_L, tk);
        else if (sel < 75)                rd(d, tk);
        else if (sel < 78)                wr(A_ST, d, tk);
        else if (sel < 80)                wr(BASE + 32'h14, d, tk);
        else if (sel < 82)                wr(32'h2000_0020, d, tk);
        else if (sel < 83)                wr(A_CT, d, tk);
        else if (sel < 84)                wr(A_CT, d & 32'hFFFF_FFFE, tk);
        else                              step(1'b0, 1'b0, 1'b0, d, d, tk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
